hilo_muldiv: RTL
================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter HILO_RST, default 32'h0, reset value of HI and LO.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port md_start  input  1  request from EX stage, qualified by md_op.
REQ-005 SHALL have port md_op  input  3  operation code (REQ-012).
REQ-006 SHALL have port md_a  input  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
REQ-007 SHALL have port md_b  input  32  rt operand: divisor or multiplier.
REQ-008 SHALL have port md_flush  input  1  exception-commit kill, driven by exc_oc.
REQ-009 SHALL have port md_busy  output  1  operation in flight; upstream stalls HI/LO users while high.
REQ-010 SHALL have port md_done  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV.
REQ-011 SHALL have ports hi and lo  output  32 each  architectural HI/LO registers, feeding the commit stage's hilordata path.

Function
REQ-012 md_op encoding SHALL be 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are ignored, no state change.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, FIX.
REQ-014 Accept SHALL occur on an edge where state==IDLE, md_start=1 and md_flush=0; all other md_start pulses are ignored.
REQ-015 MTHI/MTLO SHALL write md_a to hi/lo on the accept edge; state stays IDLE, md_busy and md_done stay 0.
REQ-016 MULT/MULTU SHALL latch operands on the accept edge (IDLE->MUL).
REQ-017 In MUL, the next edge SHALL write the 64-bit product {hi,lo} and return to IDLE. Product is signed for MULT, unsigned for MULTU.
REQ-018 DIV/DIVU SHALL latch magnitudes and sign flags on the accept edge, clear the iteration counter, and enter DIV.
REQ-019 DIV SHALL perform one restoring radix-2 step per edge for 32 edges, then enter FIX.
REQ-020 The counter SHALL be 6 bits, increment 0..31, and leave DIV on the edge where it reads 31.
REQ-021 The FIX edge SHALL apply the sign rules, write lo=quotient and hi=remainder, and return to IDLE.
REQ-022 Signed sign rules: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-023 Divide latency SHALL be 33 edges after accept; multiply latency SHALL be 1 edge after accept.
REQ-024 Divisor zero SHALL give lo=32'hFFFFFFFF and hi=md_a (the latched value) for both DIV and DIVU, with normal 33-edge latency.
REQ-025 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-026 md_busy SHALL be 1 exactly when state is MUL, DIV or FIX.
REQ-027 md_done SHALL be 1 in the single cycle after a MULT/DIV write edge, otherwise 0.
REQ-028 md_flush=1 in any non-IDLE state SHALL return the FSM to IDLE on that edge, with no HI/LO write and no md_done.
REQ-029 A flush on the same edge as the MUL or FIX write SHALL suppress that write.
REQ-030 md_flush=1 in IDLE with md_start=1 SHALL drop the request, including MTHI/MTLO.
REQ-031 md_start while md_busy=1 SHALL be ignored; upstream holds the instruction until md_busy falls.

Reset
REQ-032 reset=1 on an edge SHALL set hi=lo=HILO_RST, state=IDLE, counter=0, md_busy=0, md_done=0; it overrides start and flush.
REQ-033 Reset mid-operation SHALL abort the operation, with no HI/LO write.

Structure
REQ-034 md_op encodings and FSM state codes SHALL be defined in the shared head.vh alongside the EXC_* codes.
REQ-035 One sub-module, div_core, SHALL hold the 32-step restoring divider datapath: remainder/quotient shift registers and counter, with start/step/fix controls from hilo_muldiv.
REQ-036 Multiply SHALL be inline; the product is registered on the MUL edge.

Verification
REQ-037 MTHI a=32'h1234, then MTLO a=32'h5678 -> hi=32'h1234, lo=32'h5678 one edge each; md_busy never rises.
REQ-038 MULT a=32'hFFFFFFFE (-2), b=3 -> after 1 edge hi=32'hFFFFFFFF, lo=32'hFFFFFFFA; md_done high 1 cycle. MULTU with the same operands -> hi=2, lo=32'hFFFFFFFA.
REQ-039 DIV a=-7, b=2 -> md_busy for 33 cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
REQ-040 DIVU a=32'hDEAD, b=0 -> lo=32'hFFFFFFFF, hi=32'hDEAD. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-041 DIV started, md_flush pulsed at iteration 10 -> IDLE next edge; hi/lo unchanged; no md_done. A new DIVU started immediately after completes correctly.
REQ-042 reset asserted during FIX -> hi=lo=0, md_busy=0. md_start while busy -> no effect on result or latency.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state codes, divider constants and small sign helpers.
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

  // The divider leaves its iterate phase on the edge where the counter reads this.
  localparam logic [5:0] DIV_LAST_CNT = 6'd31;

  // Magnitude of a 32-bit operand; only negative signed operands are negated.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditionally two's-complement negate a 32-bit value.
  function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Restoring radix-2 divider datapath: operand magnitudes, remainder and
// quotient shift registers and the iteration counter. Sequencing comes from
// hilo_muldiv through the start/step controls; the signed/zero-divisor fix-up
// is presented combinationally for the FIX edge.
module div_core
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        last,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dvsr_zero_q, dvsr_zero_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic        fits_s;

  // Next-state for the divider registers: load on start, one shift-subtract per step.
  always_comb begin
    rem_d       = rem_q;
    quot_d      = quot_q;
    dvsr_d      = dvsr_q;
    a_raw_d     = a_raw_q;
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
    dvsr_zero_d = dvsr_zero_q;
    cnt_d       = cnt_q;
    rem_sh_s    = {rem_q, quot_q[31]};
    diff_s      = rem_sh_s - {1'b0, dvsr_q};
    fits_s      = (rem_sh_s >= {1'b0, dvsr_q});
    if (start) begin
      rem_d       = 32'd0;
      quot_d      = mag32(a, is_signed);
      dvsr_d      = mag32(b, is_signed);
      a_raw_d     = a;
      neg_quot_d  = is_signed && (a[31] ^ b[31]);
      neg_rem_d   = is_signed && a[31];
      dvsr_zero_d = (b == 32'd0);
      cnt_d       = 6'd0;
    end else if (step) begin
      if (fits_s) begin
        rem_d  = diff_s[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = rem_sh_s[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= 32'd0;
      quot_q      <= 32'd0;
      dvsr_q      <= 32'd0;
      a_raw_q     <= 32'd0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvsr_zero_q <= 1'b0;
      cnt_q       <= 6'd0;
    end else begin
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      dvsr_q      <= dvsr_d;
      a_raw_q     <= a_raw_d;
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
      dvsr_zero_q <= dvsr_zero_d;
      cnt_q       <= cnt_d;
    end
  end

  // Final results: a zero divisor returns all-ones quotient and the raw dividend.
  always_comb begin
    last = (cnt_q == DIV_LAST_CNT);
    if (dvsr_zero_q) begin
      quot = 32'hFFFF_FFFF;
      rem  = a_raw_q;
    end else begin
      quot = neg_if32(quot_q, neg_quot_q);
      rem  = neg_if32(rem_q, neg_rem_q);
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: MTHI/MTLO writes, single-cycle registered
// multiply and a 33-edge restoring divide, all killable by md_flush.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        mul_signed_q, mul_signed_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        div_start_s;
  logic        div_step_s;
  logic        div_last_s;
  logic [31:0] div_quot_s;
  logic [31:0] div_rem_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] product_s;

  // Sign- or zero-extend the latched operands; low 64 bits of the product are exact either way.
  always_comb begin
    if (mul_signed_q) begin
      a_ext_s = {{32{mul_a_q[31]}}, mul_a_q};
      b_ext_s = {{32{mul_b_q[31]}}, mul_b_q};
    end else begin
      a_ext_s = {32'd0, mul_a_q};
      b_ext_s = {32'd0, mul_b_q};
    end
    product_s = a_ext_s * b_ext_s;
  end

  div_core u_div_core (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .step      (div_step_s),
    .is_signed (md_op == OP_DIV),
    .a         (md_a),
    .b         (md_b),
    .last      (div_last_s),
    .quot      (div_quot_s),
    .rem       (div_rem_s)
  );

  // FSM next state, HI/LO updates and divider controls; flush kills any write.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    done_d       = 1'b0;
    div_start_s  = 1'b0;
    div_step_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md_start && !md_flush) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              mul_a_d      = md_a;
              mul_b_d      = md_b;
              mul_signed_d = (md_op == OP_MULT);
              state_d      = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              div_start_s = 1'b1;
              state_d     = ST_DIV;
            end
            OP_MTHI: hi_d = md_a;
            OP_MTLO: lo_d = md_a;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (md_flush) begin
          state_d = ST_IDLE;
        end else begin
          hi_d    = product_s[63:32];
          lo_d    = product_s[31:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (md_flush) begin
          state_d = ST_IDLE;
        end else begin
          div_step_s = 1'b1;
          if (div_last_s) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_FIX: begin
        if (md_flush) begin
          state_d = ST_IDLE;
        end else begin
          lo_d    = div_quot_s;
          hi_d    = div_rem_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, HI/LO and registered status outputs; reset overrides start and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hi_q         <= HILO_RST;
      lo_q         <= HILO_RST;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      mul_signed_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
